// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller takes the master side; the datapath/bench takes the slave side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       INSTop;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             Link;
  logic             EXTOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             inst_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  modport master (
    input  INSTop, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD,
    output MemRead, MemWrite, IRWrite,
    output MemtoReg, RegDst, RegWrite,
    output Link, EXTOp, ALUSrcA,
    output ALUSrcB, ALUOp, PCSource,
    output inst_done, illegal_op,
    output retired, state
  );

  modport slave (
    output INSTop, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD,
    input  MemRead, MemWrite, IRWrite,
    input  MemtoReg, RegDst, RegWrite,
    input  Link, EXTOp, ALUSrcA,
    input  ALUSrcB, ALUOp, PCSource,
    input  inst_done, illegal_op,
    input  retired, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore outputs decoded from state,
// with fetch/store completion gated by the memory ready handshake.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    EXEC_I    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } st_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  st_t              st;
  logic [CNT_W-1:0] cnt;
  logic             rdy;
  logic             done;
  logic             is_r, is_lw, is_sw, is_imm;
  logic             is_beq, is_jmp, is_jal, is_ori;

  assign rdy    = bus.mem_ready;
  assign is_r   = bus.INSTop == OP_R;
  assign is_lw  = bus.INSTop == OP_LW;
  assign is_sw  = bus.INSTop == OP_SW;
  assign is_ori = bus.INSTop == OP_ORI;
  assign is_imm = is_ori || bus.INSTop == OP_ADDI;
  assign is_beq = bus.INSTop == OP_BEQ;
  assign is_jal = bus.INSTop == OP_JAL;
  assign is_jmp = is_jal || bus.INSTop == OP_J;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      if (done) cnt <= cnt + 1'b1;
      unique case (st)
        IDLE:   st <= FETCH;
        FETCH:  if (rdy) st <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_lw, is_sw: st <= MEM_ADDR;
            is_r:         st <= EXEC_R;
            is_imm:       st <= EXEC_I;
            is_beq:       st <= BRANCH;
            is_jmp:       st <= JUMP;
            default:      st <= FETCH;
          endcase
        end
        MEM_ADDR: begin
          unique case (1'b1)
            is_lw:   st <= MEM_READ;
            is_sw:   st <= MEM_WRITE;
            default: st <= FETCH;
          endcase
        end
        MEM_READ:  if (rdy) st <= MEM_WB;
        MEM_WRITE: if (rdy) st <= FETCH;
        EXEC_R:    st <= R_WB;
        EXEC_I:    st <= I_WB;
        MEM_WB, R_WB, I_WB,
        BRANCH, JUMP: st <= FETCH;
        default:   st <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.Link        = 1'b0;
    bus.EXTOp       = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal_op  = 1'b0;
    done            = 1'b0;
    unique case (st)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = rdy;
        bus.PCWrite = rdy;
      end
      DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.EXTOp      = 1'b1;
        bus.illegal_op = !(is_r || is_lw || is_sw ||
                           is_imm || is_beq || is_jmp);
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.EXTOp   = 1'b1;
      end
      MEM_READ: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEM_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 1'b1;
        done         = 1'b1;
      end
      MEM_WRITE: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        done         = rdy;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      R_WB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        done         = 1'b1;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ALUOp   = is_ori ? 2'b11 : 2'b00;
        bus.EXTOp   = !is_ori;
      end
      I_WB: begin
        bus.RegWrite = 1'b1;
        done         = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        done            = 1'b1;
      end
      // jal writes the already-incremented PC into $31
      JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        bus.RegWrite = is_jal;
        bus.Link     = is_jal;
        done         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.inst_done = done;
  assign bus.retired   = cnt;
  assign bus.state     = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: an instruction-level model queues per-cycle
// expectations; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       Link;
    logic       EXTOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       inst_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    logic [3:0]    st;
    ctl_t          ctl;
    logic [CW-1:0] ret;
  } exp_t;

  logic clk = 1'b1;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;
  int   count = 0;
  exp_t q[$];

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t actual();
    ctl_t c;
    c.PCWrite     = bus.PCWrite;
    c.PCWriteCond = bus.PCWriteCond;
    c.IorD        = bus.IorD;
    c.MemRead     = bus.MemRead;
    c.MemWrite    = bus.MemWrite;
    c.IRWrite     = bus.IRWrite;
    c.MemtoReg    = bus.MemtoReg;
    c.RegDst      = bus.RegDst;
    c.RegWrite    = bus.RegWrite;
    c.Link        = bus.Link;
    c.EXTOp       = bus.EXTOp;
    c.ALUSrcA     = bus.ALUSrcA;
    c.ALUSrcB     = bus.ALUSrcB;
    c.ALUOp       = bus.ALUOp;
    c.PCSource    = bus.PCSource;
    c.inst_done   = bus.inst_done;
    c.illegal_op  = bus.illegal_op;
    return c;
  endfunction

  function automatic bit legal(logic [5:0] op);
    return op inside {6'o00, 6'o02, 6'o03, 6'o04,
                      6'o10, 6'o15, 6'o43, 6'o53};
  endfunction

  // Control settings each step of an instruction should show.
  function automatic ctl_t model(int s, logic [5:0] op, bit rdy);
    ctl_t c = '0;
    case (s)
      1: begin
        c.MemRead = 1; c.ALUSrcB = 2'b01;
        c.IRWrite = rdy; c.PCWrite = rdy;
      end
      2: begin
        c.ALUSrcB = 2'b11; c.EXTOp = 1;
        c.illegal_op = !legal(op);
      end
      3: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.EXTOp = 1; end
      4: begin c.MemRead = 1; c.IorD = 1; end
      5: begin c.RegWrite = 1; c.MemtoReg = 1; c.inst_done = 1; end
      6: begin c.MemWrite = 1; c.IorD = 1; c.inst_done = rdy; end
      7: begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
      8: begin c.RegWrite = 1; c.RegDst = 1; c.inst_done = 1; end
      9: begin
        c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
        c.ALUOp = (op == 6'o15) ? 2'b11 : 2'b00;
        c.EXTOp = (op != 6'o15);
      end
      10: begin c.RegWrite = 1; c.inst_done = 1; end
      11: begin
        c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1;
        c.PCSource = 2'b01; c.inst_done = 1;
      end
      12: begin
        c.PCWrite = 1; c.PCSource = 2'b10; c.inst_done = 1;
        c.RegWrite = (op == 6'o03); c.Link = (op == 6'o03);
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic cyc(int s, bit rdy);
    exp_t e;
    bus.mem_ready = rdy;
    e.st  = 4'(s);
    e.ctl = model(s, bus.INSTop, rdy);
    e.ret = CW'(count);
    if (e.ctl.inst_done) count = count + 1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc();
    exp_t e;
    e = '0;
    e.ret = CW'(count);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run_inst(logic [5:0] op, int fs, int ms);
    bus.INSTop = op;
    bus.funct  = 6'($urandom);
    for (int i = 0; i < fs; i++) cyc(1, 0);
    cyc(1, 1);
    cyc(2, 1);
    case (op)
      6'o43: begin
        cyc(3, 1);
        for (int i = 0; i < ms; i++) cyc(4, 0);
        cyc(4, 1); cyc(5, 1);
      end
      6'o53: begin
        cyc(3, 1);
        for (int i = 0; i < ms; i++) cyc(6, 0);
        cyc(6, 1);
      end
      6'o00: begin cyc(7, 1); cyc(8, 1); end
      6'o10, 6'o15: begin cyc(9, 1); cyc(10, 1); end
      6'o04: cyc(11, 1);
      6'o02, 6'o03: cyc(12, 1);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a.st  = bus.state;
      a.ctl = actual();
      a.ret = bus.retired;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle t=%0t: state got %0d want %0d, ctl got %h want %h, retired got %0d want %0d",
                 $time, a.st, e.st, a.ctl, e.ctl, a.ret, e.ret);
      end
    end
  end

  initial begin
    logic [5:0] ops [8];
    ops = '{6'o00, 6'o02, 6'o03, 6'o04, 6'o10, 6'o15, 6'o43, 6'o53};
    rstn = 1'b0;
    bus.INSTop = '0;
    bus.funct = '0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) idle_cyc();
    rstn = 1'b1;
    idle_cyc();

    run_inst(6'o00, 0, 0);
    run_inst(6'o43, 0, 2);
    run_inst(6'o15, 0, 0);
    run_inst(6'o10, 1, 0);
    run_inst(6'o03, 0, 0);
    run_inst(6'o77, 0, 0);
    run_inst(6'o02, 2, 0);
    run_inst(6'o04, 0, 0);
    run_inst(6'o53, 0, 1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      run_inst(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Abort a stalled store with an asynchronous reset.
    bus.INSTop = 6'o53;
    cyc(1, 1); cyc(2, 1); cyc(3, 1);
    cyc(6, 0); cyc(6, 0);
    count = 0;
    bus.mem_ready = 1'b0;
    begin
      exp_t e;
      e = '0;
      q.push_back(e);
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 4'd0 || bus.MemWrite !== 1'b0 ||
        bus.retired !== '0) begin
      miscompares++;
      $display("FAIL async abort: state %0d MemWrite %b retired %0d, want 0 0 0",
               bus.state, bus.MemWrite, bus.retired);
    end
    @(posedge clk); #1;
    idle_cyc();
    rstn = 1'b1;
    idle_cyc();
    run_inst(6'o00, 0, 0);
    run_inst(6'o43, 1, 1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
